// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I pipeline: data width, canonical NOP and
// the {pc, instr} record carried from fetch to decode.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Depth-entry synchronous FIFO of fetch entries with flush. Head is read
// combinationally from storage at the read pointer; pointers wrap modulo Depth.
module rv_fetch_fifo
  import rv_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  fetch_entry_t                   wdata_i,
  output fetch_entry_t                   rdata_o,
  output logic [$clog2(Depth+1)-1:0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  fetch_entry_t    mem_q [Depth];

  // Next pointer/count state; flush wins over push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push_i && !pop_i) begin
        cnt_d = cnt_q + CntW'(1);
      end else if (!push_i && pop_i) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; a full push with pop overwrites the slot being read out.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/rv_fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, addresses imem, queues
// {pc, instr} pairs for decode and restarts fetch on EX redirects.
module rv_fetch_stage
  import rv_pkg::*;
#(
  parameter int unsigned N        = 1024,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  output logic [$clog2(N)-1:0]         iaddr,
  input  logic [31:0]                  idata,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instr,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_pc4,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         misalign_err
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]  fpc_q, fpc_d;
  logic         err_q, err_d;
  logic         push, pop;
  logic [CW-1:0] cnt;
  fetch_entry_t head, wentry;

  // Redirect hides the head in its own cycle so decode cannot pop stale work.
  assign out_valid = (cnt != '0) & ~redirect_valid;
  assign pop       = out_valid & out_ready;
  assign push      = ~redirect_valid & ((cnt < CW'(DEPTH)) | pop);
  assign iaddr     = fpc_q[AW+1:2];
  assign wentry    = '{pc: fpc_q, instr: idata};

  rv_fetch_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wentry),
    .rdata_o (head),
    .count_o (cnt)
  );

  // Next fetch PC and sticky misalignment flag; redirect has priority.
  always_comb begin
    fpc_d = fpc_q;
    err_d = err_q;
    if (redirect_valid) begin
      fpc_d = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) err_d = 1'b1;
    end else if (push) begin
      fpc_d = fpc_q + 32'd4;
    end
  end

  // Fetch PC and error flag registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      fpc_q <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      fpc_q <= fpc_d;
      err_q <= err_d;
    end
  end

  // Head outputs default to a harmless NOP at PC 0 when nothing is valid.
  always_comb begin
    out_instr = NOP_INSTR;
    out_pc    = '0;
    if (out_valid) begin
      out_instr = head.instr;
      out_pc    = head.pc;
    end
    out_pc4 = out_pc + 32'd4;
  end

  assign occupancy    = cnt;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_rv_fetch_stage.sv
// Self-checking bench for rv_fetch_stage: directed scenarios plus a random
// run scored against a queue-based reference model.
module tb_rv_fetch_stage;

  localparam int unsigned N     = 1024;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        CLK;
  logic        rstn, rv, rdy;
  logic [31:0] rpc, idata;
  logic [9:0]  iaddr;
  logic        out_valid, err;
  logic [31:0] out_instr, out_pc, out_pc4;
  logic [2:0]  occ;

  logic        w_rstn, w_rv, w_rdy;
  logic [31:0] w_rpc, w_idata;
  logic [9:0]  w_iaddr;
  logic        w_valid, w_err;
  logic [31:0] w_instr, w_pc, w_pc4;
  logic [2:0]  w_occ;

  int n_vec;
  int n_err;

  ent_t        mq[$];
  logic [31:0] m_fpc;
  logic        m_err;

  assign idata   = 32'hA000_0000 | {22'b0, iaddr};
  assign w_idata = 32'hA000_0000 | {22'b0, w_iaddr};

  rv_fetch_stage #(.N(N), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST_N(rstn), .iaddr(iaddr), .idata(idata),
    .redirect_valid(rv), .redirect_pc(rpc), .out_valid(out_valid),
    .out_ready(rdy), .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4),
    .occupancy(occ), .misalign_err(err)
  );

  rv_fetch_stage #(.N(N), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_w (
    .CLK(CLK), .RST_N(w_rstn), .iaddr(w_iaddr), .idata(w_idata),
    .redirect_valid(w_rv), .redirect_pc(w_rpc), .out_valid(w_valid),
    .out_ready(w_rdy), .out_instr(w_instr), .out_pc(w_pc), .out_pc4(w_pc4),
    .occupancy(w_occ), .misalign_err(w_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] imem_word(input logic [31:0] pc);
    return 32'hA000_0000 | ((pc >> 2) & 32'(N - 1));
  endfunction

  // Reference: a plain FIFO of fetched records plus a fetch PC.
  function automatic void model_update();
    ent_t e;
    if (!rstn) begin
      mq.delete();
      m_fpc = 32'h0;
      m_err = 1'b0;
    end else if (rv) begin
      mq.delete();
      m_fpc = rpc & ~32'h3;
      if (rpc[1:0] != 2'b00) m_err = 1'b1;
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (mq.size() < DEPTH) begin
        e.pc    = m_fpc;
        e.instr = imem_word(m_fpc);
        mq.push_back(e);
        m_fpc = m_fpc + 32'd4;
      end
    end
  endfunction

  task automatic step();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    rstn = 1'b0; rv = 1'b0; rdy = 1'b0; rpc = 32'h0;
    step();
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; rv = 1'b1; rpc = 32'h123; rdy = 1'b1;
    step();
    step();
    rstn = 1'b1; rv = 1'b0; rdy = 1'b0;
    #1;
    n_vec++; if (occ !== 3'd0) begin n_err++; $display("FAIL reset_occ: got %0d expected 0", occ); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_instr !== NOP) begin n_err++; $display("FAIL reset_instr: got %h expected %h", out_instr, NOP); end
    n_vec++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
    n_vec++; if (out_pc4 !== 32'h4) begin n_err++; $display("FAIL reset_pc4: got %h expected 4", out_pc4); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err); end
    n_vec++; if (iaddr !== 10'd0) begin n_err++; $display("FAIL reset_iaddr: got %0d expected 0", iaddr); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    rdy = 1'b0;
    repeat (4) step();
    #1;
    n_vec++; if (occ !== 3'd4) begin n_err++; $display("FAIL bp_occ: got %0d expected 4", occ); end
    n_vec++; if (iaddr !== 10'd4) begin n_err++; $display("FAIL bp_iaddr: got %0d expected 4", iaddr); end
    n_vec++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL bp_pc: got %h expected 0", out_pc); end
    n_vec++; if (out_instr !== 32'hA000_0000) begin n_err++; $display("FAIL bp_instr: got %h expected a0000000", out_instr); end
    step();
    #1;
    n_vec++; if (occ !== 3'd4) begin n_err++; $display("FAIL bp_hold_occ: got %0d expected 4", occ); end
    n_vec++; if (iaddr !== 10'd4) begin n_err++; $display("FAIL bp_hold_iaddr: got %0d expected 4", iaddr); end
  endtask

  task automatic test_streaming();
    apply_reset();
    rdy = 1'b1;
    step();
    #1;
    for (int k = 0; k < 6; k++) begin
      n_vec++; if (out_pc !== 32'(4 * k)) begin n_err++; $display("FAIL stream_pc: got %h expected %h", out_pc, 32'(4 * k)); end
      n_vec++; if (out_pc4 !== 32'(4 * k + 4)) begin n_err++; $display("FAIL stream_pc4: got %h expected %h", out_pc4, 32'(4 * k + 4)); end
      n_vec++; if (occ !== 3'd1) begin n_err++; $display("FAIL stream_occ: got %0d expected 1", occ); end
      step();
      #1;
    end
  endtask

  task automatic test_redirect_full();
    apply_reset();
    rdy = 1'b0;
    repeat (5) step();
    rv = 1'b1; rpc = 32'h200;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_cycle_valid: got %b expected 0", out_valid); end
    step();
    rv = 1'b0;
    #1;
    n_vec++; if (occ !== 3'd0) begin n_err++; $display("FAIL redir_occ: got %0d expected 0", occ); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid: got %b expected 0", out_valid); end
    n_vec++; if (iaddr !== 10'h80) begin n_err++; $display("FAIL redir_iaddr: got %h expected 80", iaddr); end
    step();
    #1;
    n_vec++; if (out_pc !== 32'h200) begin n_err++; $display("FAIL redir_pc: got %h expected 200", out_pc); end
    n_vec++; if (out_instr !== 32'hA000_0080) begin n_err++; $display("FAIL redir_instr: got %h expected a0000080", out_instr); end
  endtask

  task automatic test_misalign();
    apply_reset();
    rv = 1'b1; rpc = 32'h102;
    step();
    rv = 1'b0; rdy = 1'b1;
    #1;
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL mis_err: got %b expected 1", err); end
    n_vec++; if (iaddr !== 10'h40) begin n_err++; $display("FAIL mis_iaddr: got %h expected 40", iaddr); end
    step();
    #1;
    n_vec++; if (out_pc !== 32'h100) begin n_err++; $display("FAIL mis_pc: got %h expected 100", out_pc); end
    rv = 1'b1; rpc = 32'h300;
    step();
    rv = 1'b0;
    repeat (2) step();
    #1;
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL mis_sticky: got %b expected 1", err); end
    n_vec++; if (out_pc !== 32'h304) begin n_err++; $display("FAIL mis_pc2: got %h expected 304", out_pc); end
    apply_reset();
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL mis_clear: got %b expected 0", err); end
  endtask

  task automatic test_full_pop();
    apply_reset();
    rdy = 1'b0;
    repeat (4) step();
    rdy = 1'b1;
    #1;
    n_vec++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL fp_head: got %h expected 0", out_pc); end
    step();
    rdy = 1'b0;
    #1;
    n_vec++; if (occ !== 3'd4) begin n_err++; $display("FAIL fp_occ: got %0d expected 4", occ); end
    n_vec++; if (out_pc !== 32'h4) begin n_err++; $display("FAIL fp_next: got %h expected 4", out_pc); end
    n_vec++; if (iaddr !== 10'd5) begin n_err++; $display("FAIL fp_iaddr: got %0d expected 5", iaddr); end
    rdy = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      n_vec++; if (out_pc !== 32'(4 + 4 * k)) begin n_err++; $display("FAIL fp_order: got %h expected %h", out_pc, 32'(4 + 4 * k)); end
      n_vec++; if (occ !== 3'd4) begin n_err++; $display("FAIL fp_drain_occ: got %0d expected 4", occ); end
      step();
      #1;
    end
    rv = 1'b1; rpc = 32'h40;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fp_redir_valid: got %b expected 0", out_valid); end
    step();
    rv = 1'b0; rdy = 1'b0;
    #1;
    n_vec++; if (occ !== 3'd0) begin n_err++; $display("FAIL fp_redir_occ: got %0d expected 0", occ); end
    step();
    #1;
    n_vec++; if (out_pc !== 32'h40) begin n_err++; $display("FAIL fp_redir_pc: got %h expected 40", out_pc); end
  endtask

  task automatic test_random();
    logic        exp_valid;
    logic [31:0] exp_pc, exp_instr;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      rstn = ($urandom_range(0, 63) != 0);
      rv   = ($urandom_range(0, 7) == 0);
      rdy  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) rpc = $urandom;
      else rpc = ($urandom_range(0, 1023) << 2) |
                 (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
      #1;
      exp_valid = (mq.size() > 0) && !rv;
      exp_pc    = exp_valid ? mq[0].pc : 32'h0;
      exp_instr = exp_valid ? mq[0].instr : NOP;
      n_vec++; if (out_valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid: cyc %0d got %b expected %b", i, out_valid, exp_valid); end
      n_vec++; if (out_pc !== exp_pc) begin n_err++; $display("FAIL rnd_pc: cyc %0d got %h expected %h", i, out_pc, exp_pc); end
      n_vec++; if (out_instr !== exp_instr) begin n_err++; $display("FAIL rnd_instr: cyc %0d got %h expected %h", i, out_instr, exp_instr); end
      n_vec++; if (out_pc4 !== exp_pc + 32'd4) begin n_err++; $display("FAIL rnd_pc4: cyc %0d got %h expected %h", i, out_pc4, exp_pc + 32'd4); end
      n_vec++; if (occ !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_occ: cyc %0d got %0d expected %0d", i, occ, mq.size()); end
      n_vec++; if (iaddr !== 10'((m_fpc >> 2) & 32'(N - 1))) begin n_err++; $display("FAIL rnd_iaddr: cyc %0d got %0d expected %0d", i, iaddr, (m_fpc >> 2) & 32'(N - 1)); end
      n_vec++; if (err !== m_err) begin n_err++; $display("FAIL rnd_err: cyc %0d got %b expected %b", i, err, m_err); end
      step();
    end
    rstn = 1'b1; rv = 1'b0;
  endtask

  task automatic test_wrap();
    w_rdy = 1'b1; w_rv = 1'b0; w_rstn = 1'b0;
    step();
    w_rstn = 1'b1;
    #1;
    n_vec++; if (w_iaddr !== 10'd1022) begin n_err++; $display("FAIL wrap_iaddr0: got %0d expected 1022", w_iaddr); end
    step();
    #1;
    n_vec++; if (w_pc !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_pc0: got %h expected fffffff8", w_pc); end
    n_vec++; if (w_iaddr !== 10'd1023) begin n_err++; $display("FAIL wrap_iaddr1: got %0d expected 1023", w_iaddr); end
    step();
    #1;
    n_vec++; if (w_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc1: got %h expected fffffffc", w_pc); end
    n_vec++; if (w_pc4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4: got %h expected 0", w_pc4); end
    n_vec++; if (w_iaddr !== 10'd0) begin n_err++; $display("FAIL wrap_iaddr2: got %0d expected 0", w_iaddr); end
    step();
    #1;
    n_vec++; if (w_pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc2: got %h expected 0", w_pc); end
    n_vec++; if (w_instr !== 32'hA000_0000) begin n_err++; $display("FAIL wrap_instr2: got %h expected a0000000", w_instr); end
    w_rstn = 1'b0;
    step();
    w_rstn = 1'b1;
    #1;
    n_vec++; if (w_valid !== 1'b0) begin n_err++; $display("FAIL wrap_rst_valid: got %b expected 0", w_valid); end
    n_vec++; if (w_iaddr !== 10'd1022) begin n_err++; $display("FAIL wrap_rst_iaddr: got %0d expected 1022", w_iaddr); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rstn = 1'b0; rv = 1'b0; rdy = 1'b0; rpc = 32'h0;
    w_rstn = 1'b0; w_rv = 1'b0; w_rdy = 1'b0; w_rpc = 32'h0;
    m_fpc = 32'h0; m_err = 1'b0;
    @(negedge CLK);
    test_reset();
    test_backpressure();
    test_streaming();
    test_redirect_full();
    test_misalign();
    test_full_pop();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
